execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Execute (E) stage of the 5-stage RV32 pipeline, directly downstream of the decode stage.
//  - Consumes the decode stage's E-side outputs.
//  - Applies operand forwarding, runs the ALU and resolves BEQ.
//  - Computes the branch target.
//  - Holds the E->M pipeline register with stall and flush, feeding the memory stage.
// PARAMETERS
//  XLEN        32   datapath width
//  REG_AW      5    register-address width
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, asynchronous, active-low
//  ValidE       in   1      E-stage holds a real instruction (0 = bubble)
//  RegWriteE    in   1      control from decode
//  ResultSrcE   in   1      control from decode
//  MemWriteE    in   1      control from decode
//  BranchE      in   1      instruction is BEQ
//  ALUSrcE      in   1      0: SrcB = forwarded RD2; 1: SrcB = ImmExtE
//  ALUControlE  in   3      ALU operation code
//  RD1E, RD2E   in   XLEN   register operands
//  ImmExtE      in   XLEN   sign-extended immediate
//  PCE          in   XLEN   instruction PC
//  PCPlus4E     in   XLEN   PC + 4
//  RdE          in   REG_AW destination register
//  ForwardAE    in   2      00 RD1E; 01 ResultW; 10 ALUResultM; 11 treated as 00
//  ForwardBE    in   2      same encoding, applied to RD2E
//  ResultW      in   XLEN   writeback-stage result
//  StallM       in   1      hold the E->M register
//  FlushM       in   1      load a bubble into the E->M register
//  ZeroE        out  1      ALU result == 0 (combinational)
//  PCSrcE       out  1      ValidE & BranchE & ZeroE (combinational)
//  PCTargetE    out  XLEN   PCE + ImmExtE, modulo 2^XLEN (combinational)
//  ValidM, RegWriteM, ResultSrcM, MemWriteM   out 1 each   registered
//  ALUResultM   out  XLEN   registered; also the forwarding source
//  WriteDataM   out  XLEN   registered forwarded RD2 (store data)
//  RdM          out  REG_AW registered
//  PCPlus4M     out  XLEN   registered
// BEHAVIOUR
//  Reset
//  - rst=0 asynchronously clears every registered output to 0 (ValidM=0, all controls 0).
//  - Reset mid-operation discards the in-flight instruction; no partial state survives.
//  Datapath (combinational, same cycle)
//  - SrcA = fwd(ForwardAE); WriteDataE = fwd(ForwardBE); SrcB = ALUSrcE ? ImmExtE : WriteDataE.
//  - ALU ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//    101 SLT (signed, result 0/1), 110 SLL, 111 SRL (logical).
//  - Shifts use SrcB[4:0]. ADD/SUB wrap modulo 2^XLEN with no overflow flag.
//  - ZeroE is computed from the ALU result every cycle, whatever ValidE is.
//  - PCSrcE is gated by ValidE so a bubble never redirects fetch.
//  E->M register (one-cycle latency)
//  - Priority at each clk edge: FlushM > StallM > load.
//  - FlushM=1: ValidM, RegWriteM and MemWriteM go to 0; other fields don't-care (implement as 0).
//  - StallM=1, FlushM=0: all M outputs hold.
//  - Otherwise load: ValidM<=ValidE; RegWriteM<=RegWriteE&ValidE; MemWriteM<=MemWriteE&ValidE;
//    the data fields load their E values.
//  - A bubble (ValidE=0) never produces RegWriteM=1 or MemWriteM=1.
//  - RdM = 0 with RegWriteM = 1 is legal; register-file x0 handling is downstream.
// STRUCTURE
//  - Shared package rv_pipe_pkg: ALU op localparams (ALU_ADD..ALU_SRL), forward-select
//    localparams (FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), XLEN/REG_AW defaults.
//  - One sub-module, alu_unit (SrcA, SrcB, ALUControl -> Result, Zero): pure combinational.
//  - Forwarding muxes, target adder and pipeline register live in execute_stage.
// TESTING
//  1. rst=0 pulse mid-stream -> all M outputs 0 immediately, with no clk edge needed.
//  2. ADD, RD1E=0x20, RD2E=0x21, ALUSrcE=0, fwd 00/00, ValidE=1
//     -> next cycle ALUResultM=0x41, RegWriteM=1.
//  3. Forwarding: ForwardAE=10 with ALUResultM=0x41; ForwardBE=01 with ResultW=5; SUB
//     -> ALUResultM=0x3C, WriteDataM=5.
//  4. BEQ, RD1E=RD2E=0x25, ImmExtE=0xFFFFFFF8, PCE=0x10
//     -> same cycle ZeroE=1, PCSrcE=1, PCTargetE=0x08. The same case with ValidE=0 -> PCSrcE=0.
//  5. SLT with 0xFFFFFFFF vs 1 -> result 1. SRL 0x80000000 by 31 -> 1.
//     SLL 1 by SrcB=0x21 -> 2 (only SrcB[4:0] used).
//  6. Load then StallM=1 for 2 cycles -> M outputs hold. Assert FlushM and StallM together
//     -> ValidM=0, RegWriteM=0, MemWriteM=0 (flush wins).

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline: widths, ALU op codes,
// forwarding selects, the E->M register layout and the forwarding mux helper.
package rv_pipe_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int SHAMT_W = $clog2(XLEN);

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Forwarding selects; 2'b11 is unused and falls back to the register value
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Contents of the E->M pipeline register
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              result_src;
    logic              mem_write;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc_plus4;
  } em_reg_t;

  // Operand forwarding: pick the freshest copy of a register operand
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] reg_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] mem_val
  );
    logic [XLEN-1:0] v;
    case (sel)
      FWD_WB:  v = wb_val;
      FWD_MEM: v = mem_val;
      default: v = reg_val;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of the execute stage's decode-side inputs, hazard controls and
// memory-side outputs. master = the surrounding pipeline, slave = execute stage.
//
// Handshake: there is no valid/ready pair here. ValidE marks a real
// instruction in E; ValidM marks a real instruction in M. StallM and FlushM
// are level-sensitive and act at the next rising clk edge, FlushM first.
interface execute_stage_if;
  import rv_pipe_pkg::*;

  // decode -> execute
  logic              ValidE;
  logic              RegWriteE;
  logic              ResultSrcE;
  logic              MemWriteE;
  logic              BranchE;
  logic              ALUSrcE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [REG_AW-1:0] RdE;
  // hazard unit / writeback
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [XLEN-1:0]   ResultW;
  logic              StallM;
  logic              FlushM;
  // execute -> fetch (combinational)
  logic              ZeroE;
  logic              PCSrcE;
  logic [XLEN-1:0]   PCTargetE;
  // execute -> memory (registered)
  logic              ValidM;
  logic              RegWriteM;
  logic              ResultSrcM;
  logic              MemWriteM;
  logic [XLEN-1:0]   ALUResultM;
  logic [XLEN-1:0]   WriteDataM;
  logic [REG_AW-1:0] RdM;
  logic [XLEN-1:0]   PCPlus4M;

  modport master (
    output ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE,
    output ForwardAE, ForwardBE, ResultW, StallM, FlushM,
    input  ZeroE, PCSrcE, PCTargetE,
    input  ValidM, RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M
  );

  modport slave (
    input  ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE,
    input  ForwardAE, ForwardBE, ResultW, StallM, FlushM,
    output ZeroE, PCSrcE, PCTargetE,
    output ValidM, RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M
  );

endinterface

// File: rtl/alu_unit.sv
// Purely combinational RV32 ALU with a zero flag. Shifts use only the low
// SHAMT_W bits of SrcB; ADD/SUB wrap with no overflow indication.
module alu_unit
  import rv_pipe_pkg::*;
(
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic [2:0]      i_alu_control,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  logic [SHAMT_W-1:0] w_shamt;
  logic               w_lt;

  assign w_shamt = i_src_b[SHAMT_W-1:0];
  assign w_lt    = $signed(i_src_a) < $signed(i_src_b);

  // Operation select
  always_comb begin
    o_result = '0;
    case (i_alu_control)
      ALU_ADD: o_result = i_src_a + i_src_b;
      ALU_SUB: o_result = i_src_a - i_src_b;
      ALU_AND: o_result = i_src_a & i_src_b;
      ALU_OR:  o_result = i_src_a | i_src_b;
      ALU_XOR: o_result = i_src_a ^ i_src_b;
      ALU_SLT: o_result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL: o_result = i_src_a << w_shamt;
      ALU_SRL: o_result = i_src_a >> w_shamt;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, BEQ resolution, branch target and
// the E->M pipeline register (flush over stall over load).
module execute_stage
  import rv_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave ex
);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_write_data_e;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;
  em_reg_t         w_em_next;
  em_reg_t         r_em;

  // Forwarded operands; ALUResultM (the M register) is the memory-stage source
  assign w_src_a        = fwd_mux(ex.ForwardAE, ex.RD1E, ex.ResultW, r_em.alu_result);
  assign w_write_data_e = fwd_mux(ex.ForwardBE, ex.RD2E, ex.ResultW, r_em.alu_result);
  assign w_src_b        = ex.ALUSrcE ? ex.ImmExtE : w_write_data_e;

  alu_unit u_alu (
    .i_src_a       (w_src_a),
    .i_src_b       (w_src_b),
    .i_alu_control (ex.ALUControlE),
    .o_result      (w_alu_result),
    .o_zero        (w_zero)
  );

  // Branch resolution: a bubble must never redirect fetch
  assign ex.ZeroE     = w_zero;
  assign ex.PCSrcE    = ex.ValidE & ex.BranchE & w_zero;
  assign ex.PCTargetE = ex.PCE + ex.ImmExtE;

  // Next value of the E->M register: flush wins over stall, stall over load
  always_comb begin
    w_em_next = r_em;
    if (ex.FlushM) begin
      w_em_next = '0;
    end else if (!ex.StallM) begin
      w_em_next.valid      = ex.ValidE;
      w_em_next.reg_write  = ex.RegWriteE & ex.ValidE;
      w_em_next.result_src = ex.ResultSrcE;
      w_em_next.mem_write  = ex.MemWriteE & ex.ValidE;
      w_em_next.alu_result = w_alu_result;
      w_em_next.write_data = w_write_data_e;
      w_em_next.rd         = ex.RdE;
      w_em_next.pc_plus4   = ex.PCPlus4E;
    end
  end

  // E->M register with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_em <= '0;
    end else begin
      r_em <= w_em_next;
    end
  end

  assign ex.ValidM     = r_em.valid;
  assign ex.RegWriteM  = r_em.reg_write;
  assign ex.ResultSrcM = r_em.result_src;
  assign ex.MemWriteM  = r_em.mem_write;
  assign ex.ALUResultM = r_em.alu_result;
  assign ex.WriteDataM = r_em.write_data;
  assign ex.RdM        = r_em.rd;
  assign ex.PCPlus4M   = r_em.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage, checked against a
// behavioural model of the ALU, forwarding and E->M register.
module tb_execute_stage;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  execute_stage_if ifc ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (ifc)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model of the M-side register
  logic        m_valid, m_regw, m_rsrc, m_memw;
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return 32'(64'(a) * (64'd1 << sh));
      default: return 32'(64'(a) / (64'd1 << sh));
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r, input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_regw = 0; m_rsrc = 0; m_memw = 0;
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
  endtask

  task automatic set_defaults();
    ifc.ValidE = 0; ifc.RegWriteE = 0; ifc.ResultSrcE = 0; ifc.MemWriteE = 0;
    ifc.BranchE = 0; ifc.ALUSrcE = 0; ifc.ALUControlE = 3'd0;
    ifc.RD1E = 0; ifc.RD2E = 0; ifc.ImmExtE = 0; ifc.PCE = 0; ifc.PCPlus4E = 0;
    ifc.RdE = 0; ifc.ForwardAE = 0; ifc.ForwardBE = 0; ifc.ResultW = 0;
    ifc.StallM = 0; ifc.FlushM = 0;
  endtask

  task automatic set_op(input logic v, input logic [2:0] op, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic alusrc, input logic [31:0] imm);
    ifc.ValidE = v; ifc.ALUControlE = op; ifc.RD1E = rd1; ifc.RD2E = rd2;
    ifc.ALUSrcE = alusrc; ifc.ImmExtE = imm;
  endtask

  // same-cycle outputs against the model
  task automatic check_comb(input string tag);
    logic [31:0] a, wd, b, r;
    logic        z;
    #1;
    a  = ref_fwd(ifc.ForwardAE, ifc.RD1E, ifc.ResultW, m_alu);
    wd = ref_fwd(ifc.ForwardBE, ifc.RD2E, ifc.ResultW, m_alu);
    b  = ifc.ALUSrcE ? ifc.ImmExtE : wd;
    r  = ref_alu(ifc.ALUControlE, a, b);
    z  = (r == 0);
    chk({tag, ".ZeroE"}, 32'(ifc.ZeroE), 32'(z));
    chk({tag, ".PCSrcE"}, 32'(ifc.PCSrcE), 32'(ifc.ValidE && ifc.BranchE && z));
    chk({tag, ".PCTargetE"}, ifc.PCTargetE, ifc.PCE + ifc.ImmExtE);
  endtask

  task automatic check_m(input string tag);
    chk({tag, ".ValidM"}, 32'(ifc.ValidM), 32'(m_valid));
    chk({tag, ".RegWriteM"}, 32'(ifc.RegWriteM), 32'(m_regw));
    chk({tag, ".ResultSrcM"}, 32'(ifc.ResultSrcM), 32'(m_rsrc));
    chk({tag, ".MemWriteM"}, 32'(ifc.MemWriteM), 32'(m_memw));
    chk({tag, ".ALUResultM"}, ifc.ALUResultM, m_alu);
    chk({tag, ".WriteDataM"}, ifc.WriteDataM, m_wd);
    chk({tag, ".RdM"}, 32'(ifc.RdM), 32'(m_rd));
    chk({tag, ".PCPlus4M"}, ifc.PCPlus4M, m_pc4);
  endtask

  // advance one clock, update the model from the inputs held before the edge, check M
  task automatic tick(input string tag);
    logic [31:0] a, wd, b;
    a  = ref_fwd(ifc.ForwardAE, ifc.RD1E, ifc.ResultW, m_alu);
    wd = ref_fwd(ifc.ForwardBE, ifc.RD2E, ifc.ResultW, m_alu);
    b  = ifc.ALUSrcE ? ifc.ImmExtE : wd;
    @(posedge clk);
    if (ifc.FlushM) begin
      model_reset();
    end else if (!ifc.StallM) begin
      m_valid = ifc.ValidE;
      m_regw  = ifc.RegWriteE && ifc.ValidE;
      m_rsrc  = ifc.ResultSrcE;
      m_memw  = ifc.MemWriteE && ifc.ValidE;
      m_alu   = ref_alu(ifc.ALUControlE, a, b);
      m_wd    = wd;
      m_rd    = ifc.RdE;
      m_pc4   = ifc.PCPlus4E;
    end
    #1;
    check_m(tag);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    model_reset();
    set_defaults();
    rst = 1'b0;

    // reset state
    #3;
    check_m("reset");
    @(negedge clk);
    rst = 1'b1;

    // ADD 0x20 + 0x21
    set_op(1, 3'd0, 32'h20, 32'h21, 0, 32'h0);
    ifc.RegWriteE = 1; ifc.RdE = 5'd7; ifc.PCPlus4E = 32'h104;
    check_comb("add");
    tick("add");
    chk("add.alu_const", ifc.ALUResultM, 32'h41);
    chk("add.regw_const", 32'(ifc.RegWriteM), 32'd1);

    // SUB with forwarding from M and W
    set_op(1, 3'd1, 32'hDEAD_0000, 32'hBEEF_0000, 0, 32'h0);
    ifc.ForwardAE = 2'b10; ifc.ForwardBE = 2'b01; ifc.ResultW = 32'd5;
    check_comb("fwd");
    tick("fwd");
    chk("fwd.alu_const", ifc.ALUResultM, 32'h3C);
    chk("fwd.wd_const", ifc.WriteDataM, 32'h5);

    // asynchronous reset mid-stream, away from any rising edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_m("midrst");
    #2;
    rst = 1'b1;
    set_defaults();

    // BEQ taken, then the same as a bubble
    @(posedge clk); #1;
    set_op(1, 3'd1, 32'h25, 32'h25, 0, 32'hFFFF_FFF8);
    ifc.BranchE = 1; ifc.PCE = 32'h10;
    check_comb("beq");
    chk("beq.pcsrc_const", 32'(ifc.PCSrcE), 32'd1);
    chk("beq.target_const", ifc.PCTargetE, 32'h8);
    ifc.ValidE = 0;
    check_comb("beq_bubble");
    chk("beq_bubble.pcsrc_const", 32'(ifc.PCSrcE), 32'd0);
    ifc.RegWriteE = 1; ifc.MemWriteE = 1;
    tick("bubble");
    ifc.BranchE = 0; ifc.PCE = 0; ifc.RegWriteE = 1; ifc.MemWriteE = 0;

    // SLT, SRL, SLL boundary cases
    set_op(1, 3'd5, 32'hFFFF_FFFF, 32'h1, 0, 32'h0);
    check_comb("slt");
    tick("slt");
    chk("slt.const", ifc.ALUResultM, 32'h1);
    set_op(1, 3'd7, 32'h8000_0000, 32'h0, 1, 32'd31);
    check_comb("srl");
    tick("srl");
    chk("srl.const", ifc.ALUResultM, 32'h1);
    set_op(1, 3'd6, 32'h1, 32'h0, 1, 32'h21);
    check_comb("sll");
    tick("sll");
    chk("sll.const", ifc.ALUResultM, 32'h2);

    // load, stall two cycles, then flush+stall
    set_op(1, 3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'h0);
    ifc.RegWriteE = 1; ifc.MemWriteE = 1; ifc.ResultSrcE = 1; ifc.RdE = 5'd9; ifc.PCPlus4E = 32'h200;
    tick("load");
    chk("load.alu_const", ifc.ALUResultM, 32'h00F0_1234);
    set_op(1, 3'd3, 32'h1111_1111, 32'h2222_2222, 0, 32'h0);
    ifc.RdE = 5'd3; ifc.PCPlus4E = 32'h300; ifc.StallM = 1;
    tick("stall1");
    tick("stall2");
    chk("stall.alu_const", ifc.ALUResultM, 32'h00F0_1234);
    ifc.FlushM = 1;
    tick("flush");
    chk("flush.valid_const", 32'(ifc.ValidM), 32'd0);
    chk("flush.regw_const", 32'(ifc.RegWriteM), 32'd0);
    chk("flush.memw_const", 32'(ifc.MemWriteM), 32'd0);
    set_defaults();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      ifc.ValidE      = 1'($urandom_range(0, 3) != 0);
      ifc.RegWriteE   = 1'($urandom_range(0, 1));
      ifc.ResultSrcE  = 1'($urandom_range(0, 1));
      ifc.MemWriteE   = 1'($urandom_range(0, 1));
      ifc.BranchE     = 1'($urandom_range(0, 1));
      ifc.ALUSrcE     = 1'($urandom_range(0, 1));
      ifc.ALUControlE = 3'($urandom_range(0, 7));
      ifc.RD1E        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      ifc.RD2E        = ($urandom_range(0, 3) == 0) ? ifc.RD1E : $urandom;
      ifc.ImmExtE     = $urandom;
      ifc.PCE         = $urandom;
      ifc.PCPlus4E    = $urandom;
      ifc.RdE         = 5'($urandom_range(0, 31));
      ifc.ForwardAE   = 2'($urandom_range(0, 3));
      ifc.ForwardBE   = 2'($urandom_range(0, 3));
      ifc.ResultW     = $urandom;
      ifc.StallM      = 1'($urandom_range(0, 7) == 0);
      ifc.FlushM      = 1'($urandom_range(0, 7) == 0);
      check_comb("rand");
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
